// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - keyboard calculator arithmetic back end (add/sub/mul, binary-to-BCD, blanking)
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   start            operation request, honoured only in IDLE
//   op[1:0]          00 add, 01 subtract (A-B), 10 multiply, 11 reserved (result 0)
//   dig3..dig0[3:0]  operand digits: A = dig3*10+dig2, B = dig1*10+dig0; >9 reads as 0
//   res3..res0[3:0]  result digits, res0 least significant, leading zeros shown as BCD_NULL
//   neg              result is negative (subtract with A<B)
//   busy             high from LOAD through DONE
//   done             one-cycle pulse, coincident with new res*/neg
module calc_engine #(
  parameter logic [3:0] BCD_NULL = 4'd13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  output logic [3:0] res0,
  output logic [3:0] res1,
  output logic [3:0] res2,
  output logic [3:0] res3,
  output logic       neg,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_CONV,
    S_DONE
  } state_t;

  state_t      state;
  logic [6:0]  opnd_a;
  logic [6:0]  opnd_b;
  logic [1:0]  op_r;
  logic        neg_r;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  cnt;

  // Out-of-range digits (including the blank code) contribute nothing.
  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [6:0] pair_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, dec_digit(tens)};
    return (t << 3) + (t << 1) + {3'b000, dec_digit(ones)};
  endfunction

  logic [6:0] a_in;
  logic [6:0] b_in;
  assign a_in = pair_to_bin(dig3, dig2);
  assign b_in = pair_to_bin(dig1, dig0);

  // Multiply partial product: A shifted to the weight of the current B bit.
  logic [13:0] a_ext;
  logic [13:0] prod_term;
  assign a_ext     = {7'd0, opnd_a};
  assign prod_term = opnd_b[cnt[2:0]] ? (a_ext << cnt[2:0]) : 14'd0;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the binary MSB.
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic [13:0] bin_shift;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[14:0], bin[13]};
    bin_shift = {bin[12:0], 1'b0};
  end

  // Leading-zero blanking on the final conversion value; res0 always shows a digit.
  logic blank3;
  logic blank2;
  logic blank1;
  logic is_zero;
  assign blank3  = (bcd_shift[15:12] == 4'd0);
  assign blank2  = blank3 && (bcd_shift[11:8] == 4'd0);
  assign blank1  = blank2 && (bcd_shift[7:4] == 4'd0);
  assign is_zero = blank1 && (bcd_shift[3:0] == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      opnd_a <= 7'd0;
      opnd_b <= 7'd0;
      op_r   <= 2'b00;
      neg_r  <= 1'b0;
      bin    <= 14'd0;
      bcd    <= 16'd0;
      cnt    <= 4'd0;
      res0   <= BCD_NULL;
      res1   <= BCD_NULL;
      res2   <= BCD_NULL;
      res3   <= BCD_NULL;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          opnd_a <= a_in;
          opnd_b <= b_in;
          op_r   <= op;
          bin    <= 14'd0;
          cnt    <= 4'd0;
          state  <= S_CALC;
        end

        S_CALC: begin
          if (op_r == 2'b10) begin
            neg_r <= 1'b0;
            bin   <= bin + prod_term;
            if (cnt == 4'd6) begin
              cnt   <= 4'd0;
              bcd   <= 16'd0;
              state <= S_CONV;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            case (op_r)
              2'b00: begin
                bin   <= {7'd0, opnd_a} + {7'd0, opnd_b};
                neg_r <= 1'b0;
              end
              2'b01: begin
                if (opnd_a >= opnd_b) begin
                  bin   <= {7'd0, opnd_a - opnd_b};
                  neg_r <= 1'b0;
                end else begin
                  bin   <= {7'd0, opnd_b - opnd_a};
                  neg_r <= 1'b1;
                end
              end
              default: begin
                bin   <= 14'd0;
                neg_r <= 1'b0;
              end
            endcase
            cnt   <= 4'd0;
            bcd   <= 16'd0;
            state <= S_CONV;
          end
        end

        S_CONV: begin
          bcd <= bcd_shift;
          bin <= bin_shift;
          if (cnt == 4'd13) begin
            // Last shift: publish the blanked digits together with done.
            cnt   <= 4'd0;
            res0  <= bcd_shift[3:0];
            res1  <= blank1 ? BCD_NULL : bcd_shift[7:4];
            res2  <= blank2 ? BCD_NULL : bcd_shift[11:8];
            res3  <= blank3 ? BCD_NULL : bcd_shift[15:12];
            neg   <= neg_r && !is_zero;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - directed self-checking bench for calc_engine
module tb_calc_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] dig0 = 4'd0;
  logic [3:0] dig1 = 4'd0;
  logic [3:0] dig2 = 4'd0;
  logic [3:0] dig3 = 4'd0;
  logic [3:0] res0, res1, res2, res3;
  logic       neg, busy, done;

  calc_engine #(.BCD_NULL(4'd13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .dig0  (dig0),
    .dig1  (dig1),
    .dig2  (dig2),
    .dig3  (dig3),
    .res0  (res0),
    .res1  (res1),
    .res2  (res2),
    .res3  (res3),
    .neg   (neg),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;
  logic [15:0] prev_res;

  function automatic logic [15:0] res_w();
    return {res3, res2, res1, res0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                     input logic [3:0] d0, input logic [1:0] o, input bit scramble,
                     input logic [15:0] exp_res, input logic exp_neg, input int exp_lat,
                     input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 40 && busy; i++) @(posedge clk);
    @(negedge clk);
    dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0; op = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, ".busy_hi"}, busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2 && scramble) begin
        dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4; op = 2'b00;
      end
      if (k == 3) chk({tag, ".res_hold"}, res_w(), prev_res);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".res"}, res_w(), exp_res);
    chk({tag, ".neg"}, neg, exp_neg);
    prev_res = exp_res;
    @(posedge clk);
    #1;
    chk({tag, ".busy_lo"}, busy, 0);
    chk({tag, ".done_lo"}, done, 0);
  endtask

  initial begin
    int n_done;
    int done_at[4];
    int busy_low;

    prev_res = 16'hDDDD;
    repeat (3) @(negedge clk);
    chk("reset.res", res_w(), 16'hDDDD);
    chk("reset.neg", neg, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'd4, 4'd7, 4'd5, 4'd8, 2'b00, 1'b0, 16'hD105, 1'b0, 16, "add47_58");

    // Abort a 99x99 multiply at e10.
    @(negedge clk);
    dig3 = 4'd9; dig2 = 4'd9; dig1 = 4'd9; dig0 = 4'd9; op = 2'b10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort.res", res_w(), 16'hDDDD);
    chk("abort.neg", neg, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort.no_done", n_done, 0);
    chk("abort.idle", busy, 0);
    prev_res = 16'hDDDD;

    run(4'd1, 4'd2, 4'd4, 4'd7, 2'b01, 1'b0, 16'hDD35, 1'b1, 16, "sub12_47");
    run(4'd4, 4'd7, 4'd4, 4'd7, 2'b01, 1'b0, 16'hDDD0, 1'b0, 16, "sub47_47");
    run(4'd5, 4'd0, 4'd0, 4'd7, 2'b01, 1'b0, 16'hDD43, 1'b0, 16, "sub50_7");
    run(4'd9, 4'd9, 4'd9, 4'd9, 2'b00, 1'b0, 16'hD198, 1'b0, 16, "add99_99");
    run(4'd9, 4'd9, 4'd9, 4'd9, 2'b10, 1'b1, 16'h9801, 1'b0, 22, "mul99_99");
    run(4'd13, 4'd6, 4'd13, 4'd3, 2'b10, 1'b0, 16'hDD18, 1'b0, 22, "mul_blank");
    run(4'd13, 4'd6, 4'd13, 4'd13, 2'b10, 1'b0, 16'hDDD0, 1'b0, 22, "mul_zero");
    run(4'd1, 4'd2, 4'd4, 4'd7, 2'b01, 1'b0, 16'hDD35, 1'b1, 16, "sub_neg2");
    run(4'd9, 4'd9, 4'd9, 4'd9, 2'b11, 1'b0, 16'hDDD0, 1'b0, 16, "reserved");

    // Extra start pulses at e5 and in the DONE cycle must be ignored.
    @(negedge clk);
    dig3 = 4'd4; dig2 = 4'd7; dig1 = 4'd5; dig0 = 4'd8; op = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    done_at[0] = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k == 17) start = 1'b0;
      if (done) begin
        if (n_done == 0) done_at[0] = k;
        n_done++;
        start = 1'b1;
      end
    end
    start = 1'b0;
    chk("hs.single_done", n_done, 1);
    chk("hs.done_edge", done_at[0], 16);
    chk("hs.res", res_w(), 16'hD105);
    chk("hs.idle", busy, 0);

    // start held high: back-to-back adds.
    @(negedge clk);
    dig3 = 4'd4; dig2 = 4'd7; dig1 = 4'd5; dig0 = 4'd8; op = 2'b00; start = 1'b1;
    n_done = 0;
    busy_low = 0;
    for (int i = 0; i < 4; i++) done_at[i] = -1;
    for (int e = 0; e <= 56; e++) begin
      @(posedge clk);
      #1;
      if (done && n_done < 4) begin
        done_at[n_done] = e;
        n_done++;
      end
      if (!busy && n_done == 1) busy_low++;
    end
    start = 1'b0;
    chk("held.first_done", done_at[0], 16);
    chk("held.spacing1", done_at[1] - done_at[0], 18);
    chk("held.spacing2", done_at[2] - done_at[1], 18);
    chk("held.busy_low", busy_low, 1);
    chk("held.res", res_w(), 16'hD105);
    for (int i = 0; i < 40 && busy; i++) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d miscompares=%0d", vectors, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_engine.md
# calc_engine

Arithmetic back end of the keyboard calculator. It reads the four BCD digit registers filled by the keyboard digit-entry logic: dig3/dig2 hold operand A, dig1/dig0 hold operand B, and value 13 is the blank code. On a start pulse it computes A+B, A−B or A×B, converts the binary result back to BCD, and presents four result digits plus a sign flag to the seven-segment display path.

## Interface
Parameters:
- BCD_NULL, 4'd13, blank-digit code, both accepted on inputs and produced on outputs.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 add, 01 subtract (A−B), 10 multiply, 11 reserved.
- dig0, dig1, dig2, dig3  in  4 each  operand digits; A = dig3·10+dig2, B = dig1·10+dig0.
- res0, res1, res2, res3  out  4 each  result digits, res0 least significant.
- neg  out  1  result is negative (subtract only).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states and transitions:
  - IDLE: goes to LOAD when start=1.
  - LOAD: latches A, B and op. Always goes to CALC.
  - CALC: one cycle for add, subtract and reserved; 7 iterations for multiply. Goes to CONV.
  - CONV: 14 double-dabble iterations. Goes to DONE.
  - DONE: goes to IDLE.
- Digit decoding: any input digit >9, including BCD_NULL, counts as 0. A tens digit of 13 with a valid ones digit yields the ones value alone. A, B are 7-bit, range 0..99.
- Operands and op are captured only in LOAD. Later changes on dig*/op have no effect until the next start.
- Arithmetic: 14-bit binary result register.
  - Add: max 198.
  - Subtract: if A≥B, magnitude A−B and neg=0. Otherwise magnitude B−A and neg=1.
  - Multiply: shift-add over B bits 0..6, one bit per cycle, LSB first. Max 9801.
  - Reserved op: result 0, neg=0.
- Conversion: sequential shift-and-add-3 over the 14-bit magnitude into four BCD nibbles, one bit per cycle, MSB first.
- Leading-zero blanking, applied when loading outputs:
  - Zero digits above the most significant nonzero digit become BCD_NULL.
  - res0 is never blanked.
  - A zero result gives res3..res0 = 13,13,13,0 with neg forced to 0.
- res*/neg update only at the transition into DONE. They hold their value in all other states, including through the next operation until its DONE.
- start in any state other than IDLE is ignored, including the DONE cycle. start held high re-triggers on each return to IDLE.

## Timing
- Reset values: res0..res3 = 13, neg=0, busy=0, done=0, FSM=IDLE, internal counters 0.
- rst_n low mid-operation aborts immediately to reset values. No done is produced.
- Let edge e0 be the edge that samples start=1 in IDLE:
  - busy goes high after e0.
  - busy is high during LOAD, CALC, CONV and DONE, and low in IDLE.
- Add/subtract/reserved:
  - LOAD after e0, CALC after e1.
  - CONV shifts on e3..e16.
  - res*/neg load on e16, and done=1 for the single cycle following e16.
  - Latency: 16 edges.
- Multiply:
  - CALC iterations on e2..e8.
  - CONV on e9..e22.
  - res*/neg load and done on e22. Latency: 22 edges.
- Minimum start-to-start spacing: 18 cycles (add/sub), 24 cycles (mul). busy falls one cycle after done rises.
- done and new res* are valid in the same cycle.

## Test plan
- Reset: start a 99×99 multiply, pull rst_n low at e10 → res3..0 = 13,13,13,13, neg=0, busy=0, no done pulse after release.
- Add: dig3..0 = 4,7,5,8, op=00, pulse start → done exactly 16 edges later, res3..0 = 13,1,0,5, neg=0.
- Subtract negative: dig3..0 = 1,2,4,7, op=01 → res3..0 = 13,13,3,5, neg=1. Repeat with 4,7,4,7 → 13,13,13,0, neg=0.
- Multiply max: dig3..0 = 9,9,9,9, op=10 → done 22 edges later, res3..0 = 9,8,0,1. Hold digits changing during busy → result unchanged.
- Blank digits: dig3..0 = 13,6,13,3, op=10 → 18, i.e. res = 13,13,1,8. With dig1..0 = 13,13 → 13,13,13,0.
- Handshake: pulse start again at e5 and in the DONE cycle → ignored, single done. Hold start high continuously → back-to-back adds every 18 cycles, busy low for exactly one IDLE cycle each time.
